accum_hex_display: RTL and testbench



---
 rtl/accum_hex_display.sv | 212 +++++++++++++++++++++
 tb/tb_accum_hex_display.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/accum_hex_display.sv
// -----------------------------------------------------------------------------
// accum_hex_display
//
// Display stage for the accumulator sum. The unsigned binary Value is converted
// to four BCD digits with an iterative shift-add-3 (double-dabble) engine. The
// digits are then shown on four active-low DE-series seven-segment displays,
// with leading-zero blanking. A conversion starts on its own whenever Value
// differs from the last value captured. The HEX registers keep the previous
// result until the new one is complete, so a partial result is never shown.
//
// Ports
//   Clock   in   1   system clock, rising edge
//   Resetn  in   1   asynchronous reset, active low
//   Value   in   W   unsigned binary value to display
//   HEX0    out  7   ones digit segments, active low, bit0=a .. bit6=g
//   HEX1    out  7   tens digit segments
//   HEX2    out  7   hundreds digit segments
//   HEX3    out  7   thousands digit segments
//   Busy    out  1   high while a conversion is in progress
//   Done    out  1   one-cycle pulse when new digits reach HEX0..HEX3
//
// Parameter W (1..13) keeps 2^W-1 within four decimal digits.
//
// state   | meaning
// --------+--------------------------------------------------------------
// S_IDLE  | waiting; Value is compared against last and captured if new
// S_SHIFT | one add-3/shift iteration per cycle, W iterations in total
// S_LATCH | BCD result is encoded into the HEX registers and Done is raised
// -----------------------------------------------------------------------------
module accum_hex_display #(
    parameter int W = 10
) (
    input  logic         Clock,
    input  logic         Resetn,
    input  logic [W-1:0] Value,
    output logic [6:0]   HEX0,
    output logic [6:0]   HEX1,
    output logic [6:0]   HEX2,
    output logic [6:0]   HEX3,
    output logic         Busy,
    output logic         Done
);

    localparam int CW = (W < 2) ? 1 : $clog2(W);
    localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_ZERO  = 7'b1000000;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_LATCH = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nxt;

    logic [W-1:0]    last;
    logic [W-1:0]    bin;
    logic [15:0]     bcd;
    logic [CW-1:0]   cnt;

    logic            start;
    logic [15:0]     bcd_adj;
    logic [W+15:0]   shifted;

    logic [3:0]      dig0;
    logic [3:0]      dig1;
    logic [3:0]      dig2;
    logic [3:0]      dig3;
    logic            blank1;
    logic            blank2;
    logic            blank3;

    function automatic logic [3:0] add3(input logic [3:0] d);
        return (d >= 4'd5) ? (d + 4'd3) : d;
    endfunction

    // Active-low segment pattern, g..a. Non-decimal codes cannot come out of
    // the converter; they map to blank.
    function automatic logic [6:0] seg7(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

    assign start = (state == S_IDLE) && (Value != last);

    // -------------------------------------------------------------------------
    // FSM state register
    // -------------------------------------------------------------------------
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // -------------------------------------------------------------------------
    // FSM next state
    // -------------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = S_SHIFT;
                end
            end
            S_SHIFT: begin
                // cnt counts the shifts already done, so CNT_LAST marks the W-th
                if (cnt == CNT_LAST) begin
                    state_nxt = S_LATCH;
                end
            end
            S_LATCH: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Double-dabble iteration: correct each digit, then shift {bcd,bin} left
    // -------------------------------------------------------------------------
    always_comb begin
        bcd_adj = {add3(bcd[15:12]), add3(bcd[11:8]), add3(bcd[7:4]), add3(bcd[3:0])};
        shifted = {bcd_adj, bin} << 1;
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            last <= '0;
            bin  <= '0;
            bcd  <= '0;
            cnt  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        last <= Value;
                        bin  <= Value;
                        bcd  <= '0;
                        cnt  <= '0;
                    end
                end
                S_SHIFT: begin
                    bcd <= shifted[W+15:W];
                    bin <= shifted[W-1:0];
                    cnt <= cnt + CW'(1);
                end
                default: begin
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Display encoding with leading-zero blanking (HEX0 always lit)
    // -------------------------------------------------------------------------
    always_comb begin
        dig0   = bcd[3:0];
        dig1   = bcd[7:4];
        dig2   = bcd[11:8];
        dig3   = bcd[15:12];
        blank3 = (dig3 == 4'd0);
        blank2 = blank3 && (dig2 == 4'd0);
        blank1 = blank2 && (dig1 == 4'd0);
    end

    // -------------------------------------------------------------------------
    // Registered outputs
    // -------------------------------------------------------------------------
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            HEX0 <= SEG_ZERO;
            HEX1 <= SEG_BLANK;
            HEX2 <= SEG_BLANK;
            HEX3 <= SEG_BLANK;
            Busy <= 1'b0;
            Done <= 1'b0;
        end else begin
            // Busy follows the state being entered, so it rises on the sampling
            // edge and falls on the same edge that raises Done.
            Busy <= (state_nxt != S_IDLE);
            Done <= (state == S_LATCH);
            if (state == S_LATCH) begin
                HEX0 <= seg7(dig0);
                HEX1 <= blank1 ? SEG_BLANK : seg7(dig1);
                HEX2 <= blank2 ? SEG_BLANK : seg7(dig2);
                HEX3 <= blank3 ? SEG_BLANK : seg7(dig3);
            end
        end
    end

endmodule

// File: tb/tb_accum_hex_display.sv
module tb_accum_hex_display;

    localparam int W    = 10;
    localparam int MAXV = (1 << W) - 1;

    logic         Clock = 1'b0;
    logic         Resetn;
    logic [W-1:0] Value;
    logic [6:0]   HEX0;
    logic [6:0]   HEX1;
    logic [6:0]   HEX2;
    logic [6:0]   HEX3;
    logic         Busy;
    logic         Done;

    int total = 0;
    int bad   = 0;
    int shown = 0;   // value the display is expected to show right now

    logic [6:0] seg_tab [0:9] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                  7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                  7'b0000000, 7'b0010000};

    accum_hex_display #(.W(W)) dut (
        .Clock  (Clock),
        .Resetn (Resetn),
        .Value  (Value),
        .HEX0   (HEX0),
        .HEX1   (HEX1),
        .HEX2   (HEX2),
        .HEX3   (HEX3),
        .Busy   (Busy),
        .Done   (Done)
    );

    always #5 Clock = ~Clock;

    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    // Reference: decimal digit at position pos, blank if the number is too short
    function automatic logic [6:0] exp_hex(input int v, input int pos);
        int p = 1;
        for (int i = 0; i < pos; i++) p = p * 10;
        if (pos > 0 && v < p) return 7'b1111111;
        return seg_tab[(v / p) % 10];
    endfunction

    task automatic chk7(input string tag, input logic [6:0] got, input logic [6:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic got, input logic exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int got, input int exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_disp(input string tag, input int v);
        chk7({tag, ".hex0"}, HEX0, exp_hex(v, 0));
        chk7({tag, ".hex1"}, HEX1, exp_hex(v, 1));
        chk7({tag, ".hex2"}, HEX2, exp_hex(v, 2));
        chk7({tag, ".hex3"}, HEX3, exp_hex(v, 3));
    endtask

    // Steps until Done (bounded). Display must hold the old value meanwhile.
    task automatic wait_done(input string tag, output int n);
        n = 0;
        do begin
            step();
            n++;
            if (Done !== 1'b1) begin
                chk1({tag, ".busy_mid"}, Busy, 1'b1);
                check_disp({tag, ".hold"}, shown);
            end
        end while (Done !== 1'b1 && n < 64);
        chk1({tag, ".done"}, Done, 1'b1);
    endtask

    // Convert v; optionally change Value to v2 k cycles after Busy rises.
    task automatic convert(input string tag, input int v, input int k, input int v2);
        int n;
        Value = W'(v);
        step();
        chk1({tag, ".busy_rise"}, Busy, 1'b1);
        chk1({tag, ".no_done"}, Done, 1'b0);
        for (int i = 0; i < k; i++) begin
            step();
            chk1({tag, ".no_done"}, Done, 1'b0);
            check_disp({tag, ".hold"}, shown);
        end
        if (v2 >= 0) Value = W'(v2);
        wait_done(tag, n);
        chk_int({tag, ".latency"}, n + k, W + 1);
        shown = v;
        check_disp(tag, v);
        chk1({tag, ".busy_fall"}, Busy, 1'b0);
        step();
        chk1({tag, ".single_done"}, Done, 1'b0);
        if (v2 >= 0 && v2 != v) begin
            chk1({tag, ".restart"}, Busy, 1'b1);
            wait_done({tag, ".second"}, n);
            chk_int({tag, ".latency2"}, n, W + 1);
            shown = v2;
            check_disp({tag, ".second"}, v2);
            chk1({tag, ".busy_fall2"}, Busy, 1'b0);
            step();
            chk1({tag, ".single_done2"}, Done, 1'b0);
        end else begin
            chk1({tag, ".stay_idle"}, Busy, 1'b0);
        end
    endtask

    initial begin
        int n;
        int v;
        int v2;
        int k;

        // Reset and idle at zero
        Resetn = 1'b0;
        Value  = '0;
        step();
        step();
        chk1("rst.busy", Busy, 1'b0);
        chk1("rst.done", Done, 1'b0);
        check_disp("rst", 0);
        #2 Resetn = 1'b1;
        for (int i = 0; i < 50; i++) begin
            step();
            chk1("idle0.busy", Busy, 1'b0);
            chk1("idle0.done", Done, 1'b0);
            check_disp("idle0", 0);
        end

        // Directed values
        convert("v1023", 1023, 0, -1);
        convert("v100", 100, 0, -1);
        convert("v7", 7, 0, -1);
        convert("v5_9", 5, 3, 9);

        // Reset in the 5th SHIFT cycle
        Value = W'(512);
        step();
        chk1("v512.busy_rise", Busy, 1'b1);
        for (int i = 0; i < 4; i++) step();
        Resetn = 1'b0;
        #1;
        chk1("midrst.busy", Busy, 1'b0);
        chk1("midrst.done", Done, 1'b0);
        shown = 0;
        check_disp("midrst", 0);
        step();
        chk1("midrst.done_held", Done, 1'b0);
        check_disp("midrst_held", 0);
        #2 Resetn = 1'b1;
        step();
        chk1("v512.restart", Busy, 1'b1);
        wait_done("v512", n);
        chk_int("v512.latency", n, W + 1);
        shown = 512;
        check_disp("v512", 512);
        step();
        chk1("v512.single_done", Done, 1'b0);

        // Boundaries: full scale and back to zero
        convert("vmax", MAXV, 0, -1);
        convert("vzero", 0, 0, -1);

        // Randomized values, some changing during the conversion
        for (int t = 0; t < 30; t++) begin
            do v = int'($urandom_range(0, MAXV)); while (v == shown);
            k = int'($urandom_range(0, W));
            if ($urandom_range(0, 1) == 1) v2 = int'($urandom_range(0, MAXV));
            else v2 = -1;
            convert("rand", v, k, v2);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
